// File: rtl/system_qsys_sysid_ext_if.sv
// Avalon-MM slave bus for the system-ID / housekeeping peripheral.
// The master drives the request side and the slave returns pipelined read data.
interface system_qsys_sysid_ext_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [31:0]           writedata;
    logic [3:0]            byteenable;
    logic [31:0]           readdata;
    logic                  readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/system_qsys_sysid_ext.sv
// System-ID and housekeeping slave: ID/timestamp words, 64-bit uptime counter with
// atomic hi snapshot, sticky overflow, lockable scratch registers, pipelined reads.
module system_qsys_sysid_ext #(
    parameter logic [31:0] SYS_ID       = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter int          NUM_SCRATCH  = 4,
    parameter int          ADDR_WIDTH   = 4,
    parameter int          READ_LATENCY = 1,
    parameter logic [63:0] UPTIME_INIT  = 64'h0
) (
    input  logic                    clock,
    input  logic                    reset,
    system_qsys_sysid_ext_if.slave  avs
);
    localparam logic [ADDR_WIDTH-1:0] A_ID      = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_TS      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_UP_LO   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_UP_HI   = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_CONTROL = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(5);

    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wd;
    logic [3:0]            be;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  scr_hit;
    logic                  clr_pulse;
    logic                  wrap;

    logic [63:0] cnt;
    logic [31:0] hi_shadow;
    logic        ctrl_en;
    logic        ctrl_lock;
    logic        ovf;
    logic [31:0] scratch [8];
    logic [31:0] rd_mux;

    assign addr    = avs.address;
    assign wd      = avs.writedata;
    assign be      = avs.byteenable;
    // A write wins over a simultaneous read; the read is simply dropped.
    assign rd_acc  = avs.read & ~avs.write;
    assign wr_acc  = avs.write;
    assign scr_hit = addr[3] && (int'(addr[2:0]) < NUM_SCRATCH);

    assign clr_pulse = wr_acc && (addr == A_CONTROL) && be[0] && wd[1];
    assign wrap      = ctrl_en && !clr_pulse && (cnt == '1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= UPTIME_INIT;
        end else if (clr_pulse) begin
            cnt <= '0;
        end else if (ctrl_en) begin
            cnt <= cnt + 64'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_en   <= 1'b1;
            ctrl_lock <= 1'b0;
        end else if (wr_acc && (addr == A_CONTROL)) begin
            if (be[0]) ctrl_en   <= wd[0];
            if (be[1]) ctrl_lock <= wd[8];
        end
    end

    // Wrap takes priority over a concurrent W1C so an overflow is never lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (wrap) begin
            ovf <= 1'b1;
        end else if (wr_acc && (addr == A_STATUS) && be[0] && wd[0]) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_shadow <= '0;
        end else if (rd_acc && (addr == A_UP_LO)) begin
            hi_shadow <= cnt[63:32];
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_scratch
        localparam bit LIVE = (gi < NUM_SCRATCH);
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                scratch[gi] <= '0;
            end else if (LIVE && wr_acc && !ctrl_lock && (addr == ADDR_WIDTH'(8 + gi))) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) scratch[gi][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_ID:      rd_mux = SYS_ID;
            A_TS:      rd_mux = TIMESTAMP;
            A_UP_LO:   rd_mux = cnt[31:0];
            A_UP_HI:   rd_mux = hi_shadow;
            A_CONTROL: rd_mux = {23'b0, ctrl_lock, 7'b0, ctrl_en};
            A_STATUS:  rd_mux = {31'b0, ovf};
            default:   if (scr_hit) rd_mux = scratch[addr[2:0]];
        endcase
    end

    // Stage p0: capture register state at the read edge.
    logic [31:0] data_p0;
    logic        vld_p0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else begin
            vld_p0 <= rd_acc;
            if (rd_acc) data_p0 <= rd_mux;
        end
    end

    // Stage p1: optional extra read stage.
    if (READ_LATENCY == 2) begin : g_lat2
        logic [31:0] data_p1;
        logic        vld_p1;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                vld_p1  <= 1'b0;
                data_p1 <= '0;
            end else begin
                vld_p1 <= vld_p0;
                if (vld_p0) data_p1 <= data_p0;
            end
        end

        assign avs.readdata      = data_p1;
        assign avs.readdatavalid = vld_p1;
    end else begin : g_lat1
        assign avs.readdata      = data_p0;
        assign avs.readdatavalid = vld_p0;
    end
endmodule

// File: tb/tb_system_qsys_sysid_ext.sv
// Directed bench: DUT 0 runs with one-cycle reads, DUT 1 with two-cycle reads,
// each started from an uptime value close to a carry or wrap boundary.
module tb_system_qsys_sysid_ext;
    localparam logic [31:0] SID = 32'h607F_A1EC;
    localparam logic [31:0] TST = 32'h5A0B_1C00;

    logic clock;
    logic reset;

    logic [3:0]  addr  [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic [31:0] rdata [2];
    logic        rvld  [2];

    int n_checks = 0;
    int n_fail   = 0;

    system_qsys_sysid_ext_if #(.ADDR_WIDTH(4)) bus0 ();
    system_qsys_sysid_ext_if #(.ADDR_WIDTH(4)) bus1 ();

    assign bus0.address    = addr[0];
    assign bus0.read       = rd[0];
    assign bus0.write      = wr[0];
    assign bus0.writedata  = wdata[0];
    assign bus0.byteenable = be[0];
    assign rdata[0]        = bus0.readdata;
    assign rvld[0]         = bus0.readdatavalid;

    assign bus1.address    = addr[1];
    assign bus1.read       = rd[1];
    assign bus1.write      = wr[1];
    assign bus1.writedata  = wdata[1];
    assign bus1.byteenable = be[1];
    assign rdata[1]        = bus1.readdata;
    assign rvld[1]         = bus1.readdatavalid;

    system_qsys_sysid_ext #(
        .SYS_ID(SID), .TIMESTAMP(TST), .NUM_SCRATCH(4), .ADDR_WIDTH(4),
        .READ_LATENCY(1), .UPTIME_INIT(64'h0000_0000_FFFF_FFFD)
    ) dut0 (
        .clock(clock), .reset(reset), .avs(bus0)
    );

    system_qsys_sysid_ext #(
        .SYS_ID(SID), .TIMESTAMP(TST), .NUM_SCRATCH(4), .ADDR_WIDTH(4),
        .READ_LATENCY(2), .UPTIME_INIT(64'hFFFF_FFFF_FFFF_FFFE)
    ) dut1 (
        .clock(clock), .reset(reset), .avs(bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_read(input int d, input logic [3:0] a, input logic [31:0] exp,
                            input string tag);
        int          lat;
        logic [31:0] got;
        lat = 0;
        got = '0;
        @(negedge clock);
        addr[d] = a;
        rd[d]   = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            if (k == 1) rd[d] = 1'b0;
            if (rvld[d]) begin
                lat = k;
                got = rdata[d];
                break;
            end
        end
        check(tag, got, exp);
        check({tag, "_lat"}, 32'(lat), (d == 0) ? 32'd1 : 32'd2);
    endtask

    task automatic bus_write(input int d, input logic [3:0] a, input logic [31:0] data,
                             input logic [3:0] lanes);
        @(negedge clock);
        addr[d]  = a;
        wdata[d] = data;
        be[d]    = lanes;
        wr[d]    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        wr[d] = 1'b0;
    endtask

    task automatic bus_read_write(input int d, input logic [3:0] a, input logic [31:0] data);
        logic saw;
        saw = 1'b0;
        @(negedge clock);
        addr[d]  = a;
        wdata[d] = data;
        be[d]    = 4'hF;
        rd[d]    = 1'b1;
        wr[d]    = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            if (k == 1) begin
                rd[d] = 1'b0;
                wr[d] = 1'b0;
            end
            if (rvld[d]) saw = 1'b1;
        end
        check("rw_no_valid", {31'b0, saw}, 32'h0);
    endtask

    initial begin
        logic saw;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0; wdata[d] = '0; be[d] = '0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_rdata0", rdata[0], 32'h0);
        check("rst_rvld0", {31'b0, rvld[0]}, 32'h0);
        check("rst_rdata1", rdata[1], 32'h0);
        check("rst_rvld1", {31'b0, rvld[1]}, 32'h0);

        // DUT 0: counter starts at FFFF_FFFD; the read samples after two increments.
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        bus_read(0, 4'd2, 32'hFFFF_FFFF, "up_lo");
        repeat (4) @(posedge clock);
        bus_read(0, 4'd3, 32'h0, "up_hi_shadow");

        bus_read(0, 4'd0, SID, "id0");
        bus_read(0, 4'd1, TST, "ts0");
        bus_read(0, 4'd4, 32'h1, "ctrl0");
        bus_read(0, 4'd5, 32'h0, "status0");
        bus_read(0, 4'd8, 32'h0, "scr0_rst");

        bus_write(0, 4'd8, 32'hDEAD_BEEF, 4'b0011);
        bus_read(0, 4'd8, 32'h0000_BEEF, "scr_be");
        bus_write(0, 4'd4, 32'h0000_0101, 4'hF);
        bus_write(0, 4'd8, 32'h1234_5678, 4'hF);
        bus_read(0, 4'd8, 32'h0000_BEEF, "scr_locked");
        bus_read(0, 4'd4, 32'h0000_0101, "ctrl_lock");
        bus_write(0, 4'd4, 32'h0000_0001, 4'hF);

        bus_read_write(0, 4'd9, 32'hA5A5_A5A5);
        bus_read(0, 4'd9, 32'hA5A5_A5A5, "scr1_rw");
        bus_read(0, 4'd15, 32'h0, "addr15");

        // DUT 1: counter starts two below the 64-bit wrap.
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        bus_read(1, 4'd5, 32'h0, "status_prewrap");
        bus_read(1, 4'd0, SID, "id1");
        bus_read(1, 4'd1, TST, "ts1");
        bus_read(1, 4'd4, 32'h1, "ctrl1");
        bus_read(1, 4'd8, 32'h0, "scr0_rst1");
        bus_read(1, 4'd5, 32'h1, "status_ovf");
        bus_write(1, 4'd5, 32'h1, 4'hF);
        bus_read(1, 4'd5, 32'h0, "status_w1c");

        bus_write(1, 4'd4, 32'h2, 4'hF);
        bus_read(1, 4'd2, 32'h0, "lo_after_clr");
        bus_read(1, 4'd2, 32'h0, "lo_held_en0");
        bus_read(1, 4'd4, 32'h0, "ctrl_clr_reads0");
        bus_write(1, 4'd4, 32'h3, 4'hF);
        bus_read(1, 4'd2, 32'h1, "lo_clr_run");

        // Reset lands while a two-cycle read is still in flight.
        @(negedge clock);
        addr[1] = 4'd0;
        rd[1]   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rd[1] = 1'b0;
        reset = 1'b1;
        saw   = rvld[1];
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (rvld[1]) saw = 1'b1;
            if (k == 2) reset = 1'b0;
        end
        check("rst_mid_vld", {31'b0, saw}, 32'h0);
        check("rst_mid_data", rdata[1], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
